bcd_display_scanner: RTL and testbench

Upstream feeder for the seven-segment decoder in the temperature-controller display path. It takes a binary reading (for example a temperature value) and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto a single 4-bit `bcd` bus, with matching active-low digit enables. The decoder consumes `bcd` combinationally; `dig_an` drives the display commons.

---
 rtl/bcd_display_scanner_if.sv | 28 ++
 rtl/bcd_display_scanner.sv | 146 ++++++++++++++
 tb/tb_bcd_display_scanner.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_if.sv
// Display scanner port bundle: load request, level controls and scan outputs.
// The controller drives the master side; the scanner is the slave.
interface bcd_display_scanner_if;
    logic [13:0] value;
    logic        load;
    logic        blank_lz;
    logic        busy;
    logic [3:0]  bcd;
    logic [3:0]  dig_an;

    modport master (
        output value,
        output load,
        output blank_lz,
        input  busy,
        input  bcd,
        input  dig_an
    );

    modport slave (
        input  value,
        input  load,
        input  blank_lz,
        output busy,
        output bcd,
        output dig_an
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD double-dabble converter feeding a 4-digit multiplexed
// seven-segment scan with leading-zero blanking and out-of-range display.
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_display_scanner_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] scr_q, scr_d;
    logic [3:0]  it_q, it_d;
    logic        cerr_q, cerr_d;
    logic [15:0] disp_q, disp_d;
    logic        derr_q, derr_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          run_q, run_d;
    logic          tick;

    logic [3:0]  bcd_q, bcd_d;
    logic [3:0]  an_q, an_d;

    logic [15:0] adj;
    logic [29:0] sh;
    logic [3:0]  digit;
    logic        z1, z2, z3;
    logic        blank;

    // Conversion, refresh and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            it_q    <= '0;
            cerr_q  <= 1'b0;
            disp_q  <= '0;
            derr_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= 2'd3;
            run_q   <= 1'b0;
            bcd_q   <= 4'h0;
            an_q    <= 4'b1111;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            it_q    <= it_d;
            cerr_q  <= cerr_d;
            disp_q  <= disp_d;
            derr_q  <= derr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            bcd_q   <= bcd_d;
            an_q    <= an_d;
        end
    end

    // Double-dabble FSM: add-3 correction then shift, 14 iterations
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        it_d    = it_q;
        cerr_d  = cerr_q;
        disp_d  = disp_q;
        derr_d  = derr_q;
        adj     = scr_q;
        for (int i = 0; i < 4; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        sh = {adj, bin_q} << 1;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    bin_d   = bus.value;
                    scr_d   = '0;
                    cerr_d  = (bus.value > 14'd9999);
                    it_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, bin_d} = sh;
                it_d = it_q + 4'd1;
                if (it_q == 4'd13) begin
                    disp_d  = sh[29:14];
                    derr_d  = cerr_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Refresh divider and digit index; first tick arms the enables
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;
        run_d = run_q | tick;
    end

    // Next scan outputs for the slot that is live after this edge
    always_comb begin
        digit = disp_q[{idx_d, 2'b00} +: 4];
        z3    = (disp_q[15:12] == 4'h0);
        z2    = z3 && (disp_q[11:8] == 4'h0);
        z1    = z2 && (disp_q[7:4] == 4'h0);
        blank = 1'b0;
        unique case (idx_d)
            2'd0: blank = 1'b0;
            2'd1: blank = z1;
            2'd2: blank = z2;
            2'd3: blank = z3;
            default: blank = 1'b0;
        endcase
        blank = blank && bus.blank_lz && !derr_q;
        bcd_d = derr_q ? 4'hE : digit;
        if (!run_d || blank) begin
            an_d = 4'b1111;
        end else begin
            an_d = ~(4'b0001 << idx_d);
        end
    end

    assign bus.busy   = (state_q == SHIFT);
    assign bus.bcd    = bcd_q;
    assign bus.dig_an = an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: conversions, scan order,
// blanking, out-of-range display, load-while-busy and async reset.
module tb_bcd_display_scanner;

    localparam int DIV = 4;

    typedef struct packed {
        logic [15:0] d;
        logic        err;
    } disp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    disp_t sbq[$];
    disp_t cur;

    bcd_display_scanner_if bus ();

    bcd_display_scanner #(
        .REFRESH_DIV(DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edges since reset release; drives the scan-position model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic disp_t mk(input int v);
        disp_t r;
        r.d   = {4'(v / 1000 % 10), 4'(v / 100 % 10),
                 4'(v / 10 % 10), 4'(v % 10)};
        r.err = (v > 9999);
        return r;
    endfunction

    function automatic void exp_out(input disp_t c, input logic blk,
                                    input int cy, output logic [3:0] an,
                                    output logic [3:0] b);
        int          idx;
        logic [15:0] d;
        logic [15:0] up;
        logic [3:0]  one;
        idx = (3 + cy / DIV) % 4;
        d   = c.d;
        up  = d >> (4 * idx);
        one = 4'b0001;
        b   = c.err ? 4'hE : d[4*idx +: 4];
        if (cy < DIV)
            an = 4'b1111;
        else if (!c.err && blk && idx >= 1 && up == 16'h0)
            an = 4'b1111;
        else
            an = ~(one << idx);
    endfunction

    task automatic scan_check(input int n, input string nm);
        logic [3:0] ea, eb;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_out(cur, bus.blank_lz, cyc, ea, eb);
            checks++;
            if (bus.dig_an !== ea) begin
                errors++;
                $display("FAIL %s dig_an cyc=%0d got=%b exp=%b",
                         nm, cyc, bus.dig_an, ea);
            end
            checks++;
            if (bus.bcd !== eb) begin
                errors++;
                $display("FAIL %s bcd cyc=%0d got=%h exp=%h",
                         nm, cyc, bus.bcd, eb);
            end
        end
    endtask

    task automatic start_load(input int v);
        @(negedge clk);
        bus.value = 14'(v);
        bus.load  = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        sbq.push_back(mk(v));
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy_rise v=%0d got=%b exp=1", v, bus.busy);
        end
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 1;
        while (bus.busy === 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1) n++;
        end
        checks++;
        if (n != 14) begin
            errors++;
            $display("FAIL %s busy_len got=%0d exp=14", nm, n);
        end
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty got=0 exp=1", nm);
        end else begin
            cur = sbq.pop_front();
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        cur          = '0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (bus.dig_an !== 4'b1111) begin
            errors++;
            $display("FAIL rst_dig_an got=%b exp=1111", bus.dig_an);
        end
        if (bus.bcd !== 4'h0) begin
            errors++;
            $display("FAIL rst_bcd got=%h exp=0", bus.bcd);
        end
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got=%b exp=0", bus.busy);
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.dig_an !== 4'b1111) begin
            errors++;
            $display("FAIL pre_tick_dig_an got=%b exp=1111", bus.dig_an);
        end
        @(posedge clk);
        #1;
        checks += 2;
        if (bus.dig_an !== 4'b1110) begin
            errors++;
            $display("FAIL first_tick_dig_an got=%b exp=1110", bus.dig_an);
        end
        if (bus.bcd !== 4'h0) begin
            errors++;
            $display("FAIL first_tick_bcd got=%h exp=0", bus.bcd);
        end
        scan_check(8, "reset_scan");
    endtask

    task automatic test_normal;
        bus.blank_lz = 1'b0;
        start_load(1234);
        wait_done("normal");
        scan_check(20, "normal_1234");
    endtask

    task automatic test_blanking;
        bus.blank_lz = 1'b1;
        start_load(7);
        wait_done("blank7");
        scan_check(16, "blank_7");
        @(negedge clk);
        bus.blank_lz = 1'b0;
        @(negedge clk);
        scan_check(16, "noblank_7");
        bus.blank_lz = 1'b1;
        start_load(0);
        wait_done("blank0");
        scan_check(16, "blank_0");
        start_load(9999);
        wait_done("v9999");
        scan_check(16, "blank_9999");
    endtask

    task automatic test_out_of_range;
        bus.blank_lz = 1'b1;
        start_load(10000);
        wait_done("err10000");
        scan_check(16, "err_10000");
        start_load(16383);
        wait_done("err16383");
        scan_check(8, "err_16383");
        start_load(42);
        wait_done("after_err");
        scan_check(16, "after_err_42");
    endtask

    task automatic test_load_busy;
        bus.blank_lz = 1'b0;
        start_load(5678);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus.load  = (c == 3 || c == 14);
            bus.value = 14'd1111;
            @(posedge clk);
            #1;
            bus.load = 1'b0;
            checks++;
            if (bus.busy !== (c < 14)) begin
                errors++;
                $display("FAIL lwb_busy c=%0d got=%b exp=%b",
                         c, bus.busy, (c < 14));
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL lwb_no_restart got=%b exp=0", bus.busy);
        end
        cur = sbq.pop_front();
        scan_check(16, "lwb_5678");
    endtask

    task automatic test_back_to_back;
        bus.blank_lz = 1'b0;
        start_load(1111);
        wait_done("b2b_first");
        start_load(2222);
        wait_done("b2b_second");
        scan_check(16, "b2b_2222");
    endtask

    task automatic test_reset_mid;
        bus.blank_lz = 1'b0;
        start_load(4321);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        cur = '0;
        #1;
        checks += 2;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_busy got=%b exp=0", bus.busy);
        end
        if (bus.dig_an !== 4'b1111) begin
            errors++;
            $display("FAIL mid_rst_dig_an got=%b exp=1111", bus.dig_an);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scan_check(40, "post_rst_0");
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_busy got=%b exp=0", bus.busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_normal();
        test_blanking();
        test_out_of_range();
        test_load_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
